uart_tx_scheduler: RTL

Arbitrates the single UART transmitter between the manual-control command source, the script engine, and an internal periodic feedback-query generator. It sits between the command producers and the UART TX byte interface, mirroring the receive-side decoder. `script_mode` decides which external source owns the link. Each byte is sequenced through a grant, send and inter-byte-gap state machine so the game side never sees back-to-back bytes closer than a fixed gap.

---
 rtl/dl_uart_pkg.sv | 16 +
 rtl/uart_tx_scheduler_if.sv | 26 ++
 rtl/uart_tx_query_timer.sv | 40 ++++
 rtl/uart_tx_scheduler.sv | 123 ++++++++++++
 4 files changed

// File: rtl/dl_uart_pkg.sv
// Shared UART link definitions: byte type codes, the query byte and the TX scheduler state type.
package dl_uart_pkg;

  localparam logic [1:0] TYPE_FEEDBACK = 2'b01;
  localparam logic [1:0] TYPE_QUERY    = 2'b10;

  // Type code travels in bits [1:0]; the upper bits of a query byte are zero.
  localparam logic [7:0] QUERY_BYTE = {6'b000000, TYPE_QUERY};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Request/ack sources, UART TX valid/ready byte port and status of the TX scheduler.
interface uart_tx_scheduler_if;

  logic       script_mode;
  logic       man_req;
  logic [7:0] man_data;
  logic       man_ack;
  logic       scr_req;
  logic [7:0] scr_data;
  logic       scr_ack;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;

  modport slave (
    input  script_mode, man_req, man_data, scr_req, scr_data, tx_ready,
    output man_ack, scr_ack, tx_valid, tx_data, busy
  );

  modport master (
    output script_mode, man_req, man_data, scr_req, scr_data, tx_ready,
    input  man_ack, scr_ack, tx_valid, tx_data, busy
  );

endinterface

// File: rtl/uart_tx_query_timer.sv
// Free-running period counter raising a sticky feedback-query request on each wrap.
// The wrap wins over a same-cycle clear, so a query granted as the timer wraps is re-requested.
module uart_tx_query_timer #(
  parameter int QUERY_PERIOD = 50000
) (
  input  logic uart_clk,
  input  logic rst_n,
  input  logic clr,
  output logic pending
);

  localparam int              CW   = $clog2(QUERY_PERIOD);
  localparam logic [CW-1:0]   LAST = CW'(QUERY_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          wrap;

  assign wrap = (cnt_q == LAST);

  always_comb begin
    cnt_d     = wrap ? '0 : cnt_q + CW'(1);
    pending_d = pending_q;
    if (clr) pending_d = 1'b0;
    if (wrap) pending_d = 1'b1;
  end

  always_ff @(posedge uart_clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Grants the UART TX to the mode-selected source (then the query timer when UART_TX_QUERY_EN is defined);
// ack and tx_valid rise one cycle after a sampled request, tx_valid holds under tx_ready backpressure, then GAP_CYCLES idle cycles.
module uart_tx_scheduler
  import dl_uart_pkg::*;
#(
  parameter int GAP_CYCLES   = 16,
  parameter int QUERY_PERIOD = 50000
) (
  input  logic                uart_clk,
  input  logic                rst_n,
  uart_tx_scheduler_if.slave  bus
);

  localparam int            GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  if (QUERY_PERIOD < 2) begin : g_bad_period
    $error("QUERY_PERIOD must be at least 2");
  end
  if (GAP_CYCLES < 0) begin : g_bad_gap
    $error("GAP_CYCLES must not be negative");
  end

  tx_sched_state_t state_q, state_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            man_ack_q, man_ack_d;
  logic            scr_ack_q, scr_ack_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            own_req;
  logic [7:0]      own_data;

  // Only the source selected by script_mode is ever looked at.
  assign own_req  = bus.script_mode ? bus.scr_req  : bus.man_req;
  assign own_data = bus.script_mode ? bus.scr_data : bus.man_data;

`ifdef UART_TX_QUERY_EN
  logic query_pending;
  logic query_clr;

  uart_tx_query_timer #(
    .QUERY_PERIOD (QUERY_PERIOD)
  ) u_query_timer (
    .uart_clk (uart_clk),
    .rst_n    (rst_n),
    .clr      (query_clr),
    .pending  (query_pending)
  );
`endif

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    man_ack_d  = 1'b0;
    scr_ack_d  = 1'b0;
    gap_cnt_d  = gap_cnt_q;
`ifdef UART_TX_QUERY_EN
    query_clr  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (own_req) begin
          tx_valid_d = 1'b1;
          tx_data_d  = own_data;
          man_ack_d  = ~bus.script_mode;
          scr_ack_d  = bus.script_mode;
          state_d    = SEND;
        end
`ifdef UART_TX_QUERY_EN
        else if (query_pending) begin
          tx_valid_d = 1'b1;
          tx_data_d  = QUERY_BYTE;
          query_clr  = 1'b1;
          state_d    = SEND;
        end
`endif
      end
      SEND: begin
        if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          tx_data_d  = '0;
          gap_cnt_d  = '0;
          state_d    = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        // Requests are deliberately not sampled until the full gap has elapsed.
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge uart_clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      man_ack_q  <= 1'b0;
      scr_ack_q  <= 1'b0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      man_ack_q  <= man_ack_d;
      scr_ack_q  <= scr_ack_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.man_ack  = man_ack_q;
  assign bus.scr_ack  = scr_ack_q;
  assign bus.busy     = (state_q != IDLE);

endmodule
